// File: rtl/kbd_decoder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : kbd_decoder_if
// Description : Handshake bundle between an upstream PS/2 receiver FIFO and
//               the scancode decoder (head byte, non-empty flag, overflow,
//               active-low pop request).
// Revision    : 1.0 - initial release
// ============================================================================
interface kbd_decoder_if;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;

    // FIFO side: presents bytes, receives pop requests
    modport master (
        output ready,
        output data,
        output overflow,
        input  nextdata_n
    );

    // Decoder side: consumes bytes, issues pop requests
    modport slave (
        input  ready,
        input  data,
        input  overflow,
        output nextdata_n
    );
endinterface
`default_nettype wire

// File: rtl/kbd_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : kbd_decoder
// Description : Set-2 PS/2 scancode decoder. Pops one byte at a time from an
//               upstream FIFO, tracks break/extended prefixes, reports the
//               currently held key, its ASCII code and a BCD press counter.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_decoder #(
    parameter int LOWERCASE = 1
) (
    input  wire logic       clk,
    input  wire logic       clrn,
    kbd_decoder_if.slave    fifo,
    output logic            key_valid,
    output logic [7:0]      scan_code,
    output logic [7:0]      ascii,
    output logic            ext,
    output logic [7:0]      press_cnt,
    output logic            ovf_sticky
);

    localparam logic [7:0] C_BREAK  = 8'hF0;
    localparam logic [7:0] C_EXTEND = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_nextdata_n, w_nextdata_n_nxt;
    logic [7:0] r_byte;
    logic       r_brk, r_ext_pend;

    assign fifo.nextdata_n = r_nextdata_n;

    // Main-row letters and digits only; extended codes never map to ASCII.
    function automatic logic [7:0] f_lookup(input logic [7:0] code, input logic extd);
        logic [7:0] v;
        v = 8'h00;
        case (code)
            8'h1C: v = "a";  8'h32: v = "b";  8'h21: v = "c";  8'h23: v = "d";
            8'h24: v = "e";  8'h2B: v = "f";  8'h34: v = "g";  8'h33: v = "h";
            8'h43: v = "i";  8'h3B: v = "j";  8'h42: v = "k";  8'h4B: v = "l";
            8'h3A: v = "m";  8'h31: v = "n";  8'h44: v = "o";  8'h4D: v = "p";
            8'h15: v = "q";  8'h2D: v = "r";  8'h1B: v = "s";  8'h2C: v = "t";
            8'h3C: v = "u";  8'h2A: v = "v";  8'h1D: v = "w";  8'h22: v = "x";
            8'h35: v = "y";  8'h1A: v = "z";
            8'h45: v = "0";  8'h16: v = "1";  8'h1E: v = "2";  8'h26: v = "3";
            8'h25: v = "4";  8'h2E: v = "5";  8'h36: v = "6";  8'h3D: v = "7";
            8'h3E: v = "8";  8'h46: v = "9";
            default: v = 8'h00;
        endcase
        // Letters sit at 0x61.. in lowercase; shift down by 0x20 for uppercase
        if ((LOWERCASE == 0) && (v >= 8'h61)) begin
            v = v - 8'h20;
        end
        if (extd) begin
            v = 8'h00;
        end
        return v;
    endfunction

    // Two-digit packed BCD increment, wrapping 99 -> 00
    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        logic [3:0] lo, hi;
        lo = v[3:0];
        hi = v[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // State and pop-request registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= IDLE;
            r_nextdata_n <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_nextdata_n <= w_nextdata_n_nxt;
        end
    end

    // Next state: one pop, one processing edge, one idle gap per byte
    always_comb begin
        w_state_nxt      = r_state;
        w_nextdata_n_nxt = 1'b1;
        case (r_state)
            IDLE: begin
                if (fifo.ready) begin
                    w_state_nxt      = POP;
                    w_nextdata_n_nxt = 1'b0;
                end
            end
            POP:     w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the FIFO head on the edge that issues the pop
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_byte <= 8'h00;
        end else if ((r_state == IDLE) && fifo.ready) begin
            r_byte <= fifo.data;
        end
    end

    // Byte interpretation: prefixes, releases, repeats and new presses
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_brk      <= 1'b0;
            r_ext_pend <= 1'b0;
            key_valid  <= 1'b0;
            scan_code  <= 8'h00;
            ascii      <= 8'h00;
            ext        <= 1'b0;
            press_cnt  <= 8'h00;
        end else if (r_state == POP) begin
            if (r_byte == C_BREAK) begin
                r_brk <= 1'b1;
            end else if (r_byte == C_EXTEND) begin
                r_ext_pend <= 1'b1;
            end else if (r_brk) begin
                // Release only counts for the key currently held
                if (key_valid && (r_byte == scan_code)) begin
                    key_valid <= 1'b0;
                end
                r_brk      <= 1'b0;
                r_ext_pend <= 1'b0;
            end else if (key_valid && (r_byte == scan_code) && (r_ext_pend == ext)) begin
                // Typematic repeat of the held key
                r_ext_pend <= 1'b0;
            end else begin
                scan_code  <= r_byte;
                ext        <= r_ext_pend;
                ascii      <= f_lookup(r_byte, r_ext_pend);
                key_valid  <= 1'b1;
                press_cnt  <= f_bcd_inc(press_cnt);
                r_ext_pend <= 1'b0;
            end
        end
    end

    // Overflow latch, cleared only by reset
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ovf_sticky <= 1'b0;
        end else if (fifo.overflow) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kbd_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_kbd_decoder
// Description : Self-checking bench for kbd_decoder. A queue models the
//               upstream FIFO; a reference model pushes expected outputs per
//               byte, compared when the decoder finishes each pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_decoder;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    kbd_decoder_if fa ();
    kbd_decoder_if fb ();

    // Second instance (uppercase) sees the identical byte stream
    assign fb.ready    = fa.ready;
    assign fb.data     = fa.data;
    assign fb.overflow = fa.overflow;

    logic       key_valid, ext, ovf_sticky;
    logic [7:0] scan_code, ascii, press_cnt;
    logic       key_valid_u, ext_u, ovf_sticky_u;
    logic [7:0] scan_code_u, ascii_u, press_cnt_u;

    kbd_decoder #(.LOWERCASE(1)) u_dut (
        .clk(clk), .clrn(clrn), .fifo(fa.slave),
        .key_valid(key_valid), .scan_code(scan_code), .ascii(ascii),
        .ext(ext), .press_cnt(press_cnt), .ovf_sticky(ovf_sticky)
    );

    kbd_decoder #(.LOWERCASE(0)) u_dut_uc (
        .clk(clk), .clrn(clrn), .fifo(fb.slave),
        .key_valid(key_valid_u), .scan_code(scan_code_u), .ascii(ascii_u),
        .ext(ext_u), .press_cnt(press_cnt_u), .ovf_sticky(ovf_sticky_u)
    );

    typedef struct {
        logic       kv;
        logic [7:0] sc;
        logic [7:0] al;
        logic [7:0] au;
        logic       ext;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         pop_cyc[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         low_cnt  = 0;
    logic       last_nd  = 1'b1;

    // Reference model state
    logic       m_kv, m_ext, m_brk, m_ep;
    logic [7:0] m_sc, m_al, m_au;
    int         m_cnt;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                8'h3D, 8'h3E, 8'h46};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_ascii(input logic [7:0] c, input logic x, input bit lower);
        if (x) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (letters[i] == c) return (lower ? 8'h61 : 8'h41) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digits[i] == c) return 8'h30 + 8'(i);
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_kv = 0; m_ext = 0; m_brk = 0; m_ep = 0;
        m_sc = 0; m_al = 0; m_au = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ep = 1;
        else if (m_brk) begin
            if (m_kv && b == m_sc) m_kv = 0;
            m_brk = 0; m_ep = 0;
        end else if (m_kv && b == m_sc && m_ep == m_ext) begin
            m_ep = 0;
        end else begin
            m_sc  = b;
            m_ext = m_ep;
            m_kv  = 1;
            m_cnt = (m_cnt + 1) % 100;
            m_al  = exp_ascii(b, m_ep, 1'b1);
            m_au  = exp_ascii(b, m_ep, 1'b0);
            m_ep  = 0;
        end
        e.kv = m_kv; e.sc = m_sc; e.al = m_al; e.au = m_au; e.ext = m_ext;
        e.cnt = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        exp_q.push_back(e);
    endtask

    // FIFO model and scoreboard: everything happens on the falling edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (clrn) begin
            if (!last_nd && fa.nextdata_n) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("key_valid", key_valid, e.kv);
                    check("scan_code", scan_code, e.sc);
                    check("ascii", ascii, e.al);
                    check("ext", ext, e.ext);
                    check("press_cnt", press_cnt, e.cnt);
                    check("ascii_uc", ascii_u, e.au);
                    check("key_valid_uc", key_valid_u, e.kv);
                    check("press_cnt_uc", press_cnt_u, e.cnt);
                end
            end
            if (!fa.nextdata_n) begin
                low_cnt++;
                if (last_nd) pop_cyc.push_back(cyc);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
        end
        last_nd  = fa.nextdata_n;
        fa.ready = (fifo_q.size() != 0);
        fa.data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    task automatic push_now(input logic [7:0] b);
        fifo_q.push_back(b);
        model_byte(b);
    endtask

    task automatic send1(input logic [7:0] b);
        @(posedge clk); #2;
        push_now(b);
    endtask

    task automatic drain();
        bit timed_out = 1;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #2;
            if (fifo_q.size() == 0 && exp_q.size() == 0 && fa.nextdata_n) begin
                timed_out = 0;
                break;
            end
        end
        check("drain_timeout", 32'(timed_out), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        #1;
        fifo_q.delete();
        exp_q.delete();
        model_reset();
        last_nd = 1'b1;
        check("rst_nextdata_n", fa.nextdata_n, 1);
        check("rst_key_valid", key_valid, 0);
        check("rst_scan_code", scan_code, 0);
        check("rst_ascii", ascii, 0);
        check("rst_ext", ext, 0);
        check("rst_press_cnt", press_cnt, 0);
        check("rst_ovf_sticky", ovf_sticky, 0);
        repeat (2) @(posedge clk);
        #2;
        clrn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        fa.ready = 0; fa.data = 0; fa.overflow = 0;
        clrn = 1'b1;
        model_reset();
        #3;
        do_reset();

        // No pop may happen while the FIFO is empty after reset
        pop_cyc.delete();
        repeat (5) @(posedge clk);
        #2;
        check("no_pop_when_empty", pop_cyc.size(), 0);

        // Press and release of 'a'
        send1(8'h1C); send1(8'hF0); send1(8'h1C);
        drain();
        check("a_release_scan", scan_code, 8'h1C);

        // Typematic repeats are not counted
        do_reset();
        send1(8'h1C); send1(8'h1C); send1(8'h1C); send1(8'hF0); send1(8'h1C);
        drain();
        check("repeat_cnt", press_cnt, 8'h01);
        check("repeat_ascii_uc", ascii_u, 8'h41);

        // Extended key press and release
        do_reset();
        send1(8'hE0); send1(8'h75); send1(8'hE0); send1(8'hF0); send1(8'h75);
        drain();
        check("ext_held", ext, 1);

        // Last key wins; stale release ignored; extended variant of held code is a new key
        do_reset();
        send1(8'h1C); send1(8'h32); send1(8'hF0); send1(8'h1C);
        send1(8'hF0); send1(8'h32); send1(8'h05);
        send1(8'h1C); send1(8'hE0); send1(8'h1C);
        drain();
        check("mixed_cnt", press_cnt, 8'h05);

        // Back-to-back bytes: pops three cycles apart, single-cycle lows
        do_reset();
        pop_cyc.delete();
        low_cnt = 0;
        @(posedge clk); #2;
        push_now(8'h2B); push_now(8'hF0); push_now(8'h2B);
        drain();
        check("pop_count", pop_cyc.size(), 3);
        check("pop_low_cycles", low_cnt, 3);
        if (pop_cyc.size() == 3) begin
            check("pop_gap_1", pop_cyc[1] - pop_cyc[0], 3);
            check("pop_gap_2", pop_cyc[2] - pop_cyc[1], 3);
        end

        // Overflow pulse latches until reset
        @(posedge clk); #2;
        fa.overflow = 1'b1;
        @(posedge clk); #2;
        fa.overflow = 1'b0;
        check("ovf_set", ovf_sticky, 1);
        check("ovf_set_uc", ovf_sticky_u, 1);
        send1(8'h24); send1(8'hF0); send1(8'h24);
        drain();
        check("ovf_held", ovf_sticky, 1);
        do_reset();

        // 100 presses of '1': BCD carry and wrap
        for (int i = 0; i < 100; i++) begin
            send1(8'h16); send1(8'hF0); send1(8'h16);
            if (i == 9) begin
                drain();
                check("bcd_carry_10", press_cnt, 8'h10);
            end
            if (i == 98) begin
                drain();
                check("bcd_99", press_cnt, 8'h99);
            end
        end
        drain();
        check("bcd_wrap", press_cnt, 8'h00);
        check("digit_ascii", ascii, 8'h31);

        // Reset while the pop request is low releases it without a clock edge
        do_reset();
        send1(8'h1C);
        begin
            bit seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (!fa.nextdata_n) begin
                    seen = 1;
                    break;
                end
            end
            check("pop_seen", 32'(seen), 1);
        end
        #1;
        clrn = 1'b0;
        #1;
        check("async_nd_release", fa.nextdata_n, 1);
        do_reset();
        repeat (6) @(posedge clk);
        #2;
        check("discarded_kv", key_valid, 0);
        check("discarded_cnt", press_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
